// File: rtl/risc_cpu_param.sv
`timescale 1ns/1ps
// risc_cpu_param: parametrised multi-cycle accumulator CPU core.
// Each instruction steps through FETCH, DECODE and then READ/WRITE/EXEC.
// Memory is accessed over a req/ready handshake, so wait states are allowed.
// The architectural registers are exported for observation.
module risc_cpu_param #(
   parameter int                DATA_W   = 8,
   parameter int                ADDR_W   = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clock,
   input  logic              reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              halted,
   output logic              instr_done,
   output logic [ADDR_W-1:0] pc_out,
   output logic [DATA_W-1:0] ac_out,
   output logic              e_out,
   output logic [DATA_W-1:0] ir_out
);

   typedef enum logic [2:0] {
      S_START, S_FETCH, S_DECODE, S_READ, S_WRITE, S_EXEC, S_HALT
   } state_e;

   typedef enum logic [3:0] {
      OP_NOP = 4'h0, OP_LDA, OP_STA, OP_ADD, OP_AND, OP_OR, OP_XOR, OP_SUB,
      OP_JMP, OP_JZ, OP_ISZ, OP_INC, OP_CLA, OP_CMA, OP_CIL, OP_HLT
   } opcode_e;

   state_e            state, state_next;
   logic [ADDR_W-1:0] pc, ar;
   logic [DATA_W-1:0] ac, ir, dr;
   logic              e;
   opcode_e           opcode;
   logic              xfer_done;

   // The opcode sits in the top nibble; the middle bits of IR are ignored.
   assign opcode    = opcode_e'(ir[DATA_W-1 -: 4]);
   assign xfer_done = mem_req && mem_ready;

   assign halted = (state == S_HALT);
   assign pc_out = pc;
   assign ac_out = ac;
   assign e_out  = e;
   assign ir_out = ir;

   // State register; reset is asynchronous, so a pending request drops at once.
   always_ff @(posedge clock or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) state <= S_START;
      else       state <= state_next;
   end

   // Next-state and memory-port decode. Port signals depend only on state and
   // registers, so they stay steady for the whole of a wait state.
   always_comb begin
      // NOTE: each output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
      state_next = state;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = ar;
      mem_wdata  = (opcode == OP_ISZ) ? dr : ac;
      instr_done = 1'b0;
      case (state)
         S_START: state_next = S_FETCH;
         S_FETCH: begin
            mem_req  = 1'b1;
            mem_addr = pc;
            if (mem_ready) state_next = S_DECODE;
         end
         S_DECODE: begin
            case (opcode)
               OP_LDA, OP_ADD, OP_AND, OP_OR, OP_XOR, OP_SUB, OP_ISZ: state_next = S_READ;
               OP_STA: state_next = S_WRITE;
               OP_HLT: begin
                  state_next = S_HALT;
                  instr_done = 1'b1;
               end
               default: state_next = S_EXEC;
            endcase
         end
         S_READ: begin
            mem_req = 1'b1;
            if (mem_ready) state_next = (opcode == OP_ISZ) ? S_WRITE : S_EXEC;
         end
         S_WRITE: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            if (mem_ready) begin
               instr_done = 1'b1;
               state_next = S_FETCH;
            end
         end
         S_EXEC: begin
            instr_done = 1'b1;
            state_next = S_FETCH;
         end
         S_HALT:  state_next = S_HALT;
         default: state_next = S_START;
      endcase
   end

   // Architectural registers. Memory-facing states update only on a completed
   // transfer, so nothing moves while the memory holds off mem_ready.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc <= RESET_PC;
         ac <= '0;
         e  <= 1'b0;
         ir <= '0;
         ar <= '0;
         dr <= '0;
      end else begin
         case (state)
            S_FETCH: if (xfer_done) begin
               ir <= mem_rdata;
               pc <= pc + ADDR_W'(1);
            end
            S_DECODE: ar <= ir[ADDR_W-1:0];
            S_READ: if (xfer_done) begin
               dr <= (opcode == OP_ISZ) ? mem_rdata + DATA_W'(1) : mem_rdata;
            end
            S_WRITE: if (xfer_done && opcode == OP_ISZ && dr == '0) begin
               pc <= pc + ADDR_W'(1);
            end
            S_EXEC: begin
               case (opcode)
                  OP_LDA: ac <= dr;
                  OP_ADD: {e, ac} <= {1'b0, ac} + {1'b0, dr};
                  OP_AND: ac <= ac & dr;
                  OP_OR:  ac <= ac | dr;
                  OP_XOR: ac <= ac ^ dr;
                  OP_SUB: begin
                     ac <= ac - dr;
                     e  <= (ac >= dr);
                  end
                  OP_JMP: pc <= ar;
                  OP_JZ:  if (ac == '0) pc <= ar;
                  OP_INC: {e, ac} <= {1'b0, ac} + {{DATA_W{1'b0}}, 1'b1};
                  OP_CLA: begin
                     ac <= '0;
                     e  <= 1'b0;
                  end
                  OP_CMA: ac <= ~ac;
                  OP_CIL: {e, ac} <= {ac, e};
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

endmodule
